// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP tile buffer.
// Also provides the saturating layer-count increment.
package mlp_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_COLS      = 16;
    localparam int DEF_ROWS      = 16;
    localparam int DEF_TILE_ROWS = 2;
    localparam int DEF_OUT_W     = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mlp_tile_buffer_if.sv
// Write-beat and drain-stream handshake bundle of the MLP tile buffer.
// The buffer is the slave; the producer/consumer side is the master.
interface mlp_tile_buffer_if
    import mlp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COLS      = DEF_COLS,
    parameter int TILE_ROWS = DEF_TILE_ROWS,
    parameter int OUT_W     = DEF_OUT_W
);
    logic                              wr_valid_i;
    logic                              wr_ready_o;
    logic [TILE_ROWS*COLS*DATA_W-1:0]  wr_data_i;
    logic                              wr_last_layer_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [OUT_W-1:0]                  out_data_o;
    logic                              out_last_o;

    modport slave (
        input  wr_valid_i, wr_data_i, wr_last_layer_i, out_ready_i,
        output wr_ready_o, out_valid_o, out_data_o, out_last_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_last_layer_i, out_ready_i,
        input  wr_ready_o, out_valid_o, out_data_o, out_last_o
    );
endinterface

// File: rtl/mlp_drain_serializer.sv
// Walks a completed bank row by row, word by word, into OUT_W beats.
// The output register only advances on a handshake, so stalls hold data.
module mlp_drain_serializer
    import mlp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [COLS*DATA_W-1:0]     row_data_i,
    output logic [$clog2(ROWS)-1:0]    row_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_W-1:0]           out_data_o,
    output logic                       out_last_o
);
    localparam int EPW    = OUT_W / DATA_W;
    localparam int WPR    = COLS / EPW;
    localparam int RIDX_W = $clog2(ROWS);
    localparam int WIDX_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [RIDX_W-1:0] ROW_LAST  = RIDX_W'(ROWS - 1);
    localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(WPR - 1);

    logic [RIDX_W-1:0] row_q;
    logic [WIDX_W-1:0] word_q;
    logic              valid_q, last_q;
    logic [OUT_W-1:0]  data_q, beat_d;
    logic              load, final_pos;

    // Lower column index lands in the higher bits of the beat.
    always_comb begin
        beat_d = '0;
        for (int e = 0; e < EPW; e++)
            beat_d[(EPW-1-e)*DATA_W +: DATA_W] =
                row_data_i[(int'(word_q)*EPW + e)*DATA_W +: DATA_W];
    end

    assign final_pos = (row_q == ROW_LAST) && (word_q == WORD_LAST);
    assign load      = start_i || (valid_q && out_ready_i && !last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            row_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            data_q  <= beat_d;
            valid_q <= 1'b1;
            last_q  <= final_pos;
            if (word_q == WORD_LAST) begin
                word_q <= '0;
                row_q  <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                word_q <= word_q + 1'b1;
            end
        end else if (valid_q && out_ready_i && last_q) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign row_o       = row_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
endmodule

// File: rtl/mlp_tile_buffer.sv
// Ping-pong layer buffer: one bank fills with tile rows while the other
// serves feedback reads; the output layer is drained as a beat stream.
//
//   state    | meaning
//   ST_FILL  | accepting write beats into the write bank
//   ST_DRAIN | streaming the just-completed bank out
//   ST_DONE  | drain finished, waiting for clear_i
module mlp_tile_buffer
    import mlp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int TILE_ROWS = DEF_TILE_ROWS,
    parameter int OUT_W     = DEF_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    mlp_tile_buffer_if.slave         bus,
    input  logic [$clog2(ROWS)-1:0]  rd_row_i,
    output logic [COLS*DATA_W-1:0]   rd_data_o,
    output logic [7:0]               layer_cnt_o,
    output logic                     done_o
);
    localparam int BEATS  = ROWS / TILE_ROWS;
    localparam int PTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RIDX_W = $clog2(ROWS);
    localparam int ROW_W  = COLS * DATA_W;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BEATS - 1);

    state_t            state_q, state_d;
    logic              wr_bank_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [7:0]        layer_cnt_q;
    logic [ROW_W-1:0]  rd_data_q;
    logic [ROW_W-1:0]  bank_q [2][ROWS];

    logic              wr_ready, wr_accept, final_beat, drain_start;
    logic [RIDX_W-1:0] ser_row;
    logic [ROW_W-1:0]  drain_row;

    assign wr_accept      = bus.wr_valid_i && wr_ready;
    assign final_beat     = wr_accept && (wr_ptr_q == PTR_LAST);
    assign bus.wr_ready_o = wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (final_beat && bus.wr_last_layer_i) state_d = ST_DRAIN;
                ST_DRAIN: if (bus.out_valid_o && bus.out_ready_i && bus.out_last_o)
                              state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_FILL;
            endcase
        end
    end

    // The serializer is idle only on the first DRAIN cycle; that kicks it off.
    always_comb begin
        wr_ready    = (state_q == ST_FILL) && !clear_i;
        drain_start = (state_q == ST_DRAIN) && !bus.out_valid_o && !clear_i;
        done_o      = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            layer_cnt_q <= '0;
            rd_data_q   <= '0;
        end else begin
            rd_data_q <= bank_q[~wr_bank_q][rd_row_i];
            if (clear_i) begin
                wr_ptr_q    <= '0;
                layer_cnt_q <= '0;
            end else if (wr_accept) begin
                if (wr_ptr_q == PTR_LAST) begin
                    wr_ptr_q    <= '0;
                    wr_bank_q   <= ~wr_bank_q;
                    layer_cnt_q <= sat_inc8(layer_cnt_q);
                end else begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    // Bank storage carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int t = 0; t < TILE_ROWS; t++)
                bank_q[wr_bank_q][RIDX_W'(int'(wr_ptr_q)*TILE_ROWS + t)] <=
                    bus.wr_data_i[t*ROW_W +: ROW_W];
        end
    end

    assign drain_row   = bank_q[~wr_bank_q][ser_row];
    assign rd_data_o   = rd_data_q;
    assign layer_cnt_o = layer_cnt_q;

    mlp_drain_serializer #(
        .DATA_W (DATA_W),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .OUT_W  (OUT_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear_i),
        .start_i     (drain_start),
        .row_data_i  (drain_row),
        .row_o       (ser_row),
        .out_valid_o (bus.out_valid_o),
        .out_ready_i (bus.out_ready_i),
        .out_data_o  (bus.out_data_o),
        .out_last_o  (bus.out_last_o)
    );
endmodule
